fpu: RTL and testbench
======================

Name: fpu

Overview:
- Memory-mapped single-precision (IEEE-754 binary32) floating-point coprocessor on an 8-bit host bus.
- The host writes operands A and B bytewise, then writes an opcode, which starts execution.
- Completion is signalled on cmd_end (usable as an IRQ) and cleared by end_ack; the result is read back bytewise.

Parameters:
- none; all constants live in package pa_fpu.

Ports:
- clk  in  1  system clock, rising edge.
- arst  in  1  asynchronous reset, active-high.
- databus_in  in  8  host write data.
- databus_out  out  8  host read data.
- addr  in  6  register address.
- cs  in  1  chip select, active-low.
- rd  in  1  read strobe, active-low.
- wr  in  1  write strobe, active-low.
- end_ack  in  1  host acknowledge of cmd_end, active-high.
- cmd_end  out  1  command finished / IRQ, active-high, level.
- busy  out  1  operation in progress, active-high.

Behaviour:
- Reset: asynchronous and active-high on arst. Clears A, B, OP, RES, STATUS, the FSM (to IDLE), busy and cmd_end.
- Register map, byte 0 = LSB:
  - 0x00-0x03 A.
  - 0x04-0x07 B.
  - 0x08 OP (writing it starts execution).
  - 0x0C-0x0F RES (read-only).
  - 0x10 STATUS (read-only): bit0 busy, bit1 cmd_end, bit2 invalid, bit3 overflow, bit4 underflow, bits7:5 zero.
- Write: sampled on the rising clk edge while cs=0 and wr=0.
  - Edge-detected: a strobe held for several cycles counts as one write.
  - Writes to A, B or OP while busy=1 are ignored.
- Read: combinational. databus_out is the addressed byte when cs=0 and rd=0, otherwise 0x00. Unmapped addresses read 0x00.
- Opcodes (pa_fpu): op_add=0x00, op_sub=0x01, op_mul=0x02. Any other value gives RES=0x7FC00000, invalid=1, with normal timing.
- FSM:
  - IDLE -> UNPACK -> ALIGN -> EXEC -> NORM -> ROUND -> IDLE.
  - One cycle per state, so fixed latency: busy rises on the edge after the OP write and stays high for exactly 5 cycles.
  - RES, STATUS flags and cmd_end update on the edge where ROUND exits.
- cmd_end: stays high until end_ack=1 is sampled on a clk edge, or until a new OP write (which clears it). end_ack has no effect when cmd_end=0.
- Arithmetic:
  - Denormal inputs are treated as signed zero.
  - Any NaN input gives canonical quiet NaN 0x7FC00000 with invalid=1.
  - inf-inf (add/sub) and 0*inf give 0x7FC00000 with invalid=1.
  - inf operands otherwise propagate with the correct sign.
  - Rounding: round-to-nearest-even using guard/round/sticky bits.
  - Exponent overflow gives signed infinity with overflow=1.
  - A result below the minimum normal is flushed to signed zero with underflow=1.
  - Exact zero from add/sub is +0, except (-0)+(-0), which gives -0.
  - Mul sign is the XOR of operand signs. Mantissa product is 24x24 -> 48 bits.
- Reset mid-operation aborts the operation: busy=0, cmd_end=0, RES=0.
- STATUS flags are cleared when a new op starts.

Decomposition:
- Package pa_fpu holds:
  - op_t enum (op_add, op_sub, op_mul);
  - FSM state enum;
  - register address constants;
  - QNAN constant 0x7FC00000;
  - float field widths (exponent 8, mantissa 23, bias 127).
- One natural sub-module, fpu_normalize: leading-zero count, shift and round-to-nearest-even of the raw mantissa/exponent. It is shared by add/sub and mul.
- The bus register file and the FSM stay in fpu.

Test Plan:
- A=0xFFFFFFFF, B=0xFFFFFFFF, op_add -> busy high 5 cycles, then cmd_end=1, RES=0x7FC00000, STATUS bit2=1. end_ack pulse -> cmd_end=0.
- A=0x3F800000, B=0x40000000, op_add -> RES=0x40400000; read bytes 0x0C..0x0F = 00,00,40,40.
- A=0x40400000, B=0x3F800000, op_sub -> 0x40000000. With A=B=0x40400000, op_sub -> 0x00000000.
- A=0x40000000, B=0x40400000, op_mul -> 0x40C00000. A=0x7F7FFFFF, B=0x7F7FFFFF, op_add -> 0x7F800000 with overflow=1.
- Write to A during busy, plus a second OP write during busy -> both ignored; result matches the original operands.
- Assert arst during ALIGN -> busy=0, cmd_end=0, RES=0, all registers read 0x00.

Source files
------------

// File: rtl/fpu_pkg.sv
// Shared constants and datapath types for the fpu coprocessor.
package pa_fpu;
  localparam int unsigned EXP_W = 8;
  localparam int unsigned MAN_W = 23;
  localparam int unsigned BIAS  = 127;

  typedef enum logic [7:0] {
    op_add = 8'h00,
    op_sub = 8'h01,
    op_mul = 8'h02
  } op_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_UNPACK,
    ST_ALIGN,
    ST_EXEC,
    ST_NORM,
    ST_ROUND
  } state_t;

  localparam logic [5:0]  ADDR_A      = 6'h00;
  localparam logic [5:0]  ADDR_B      = 6'h04;
  localparam logic [5:0]  ADDR_OP     = 6'h08;
  localparam logic [5:0]  ADDR_RES    = 6'h0C;
  localparam logic [5:0]  ADDR_STATUS = 6'h10;
  localparam logic [31:0] QNAN        = 32'h7FC0_0000;

  // Significand carries the hidden bit; it is zero for zero and denormal inputs.
  typedef struct packed {
    logic             sign;
    logic [EXP_W-1:0] exp;
    logic [MAN_W:0]   man;
  } mag_t;

  typedef struct packed {
    logic zero;
    logic inf;
    logic nan;
    mag_t m;
  } fp_t;

  typedef struct packed {
    logic        special;
    logic [31:0] sp_res;
    logic        sp_inv;
    mag_t        hi;
    mag_t        lo;
  } unp_t;

  typedef struct packed {
    logic        sign;
    logic [9:0]  exp;
    logic [47:0] raw;
  } raw_t;

  typedef struct packed {
    logic [31:0] res;
    logic        inv;
    logic        ovf;
    logic        unf;
  } res_t;

  function automatic fp_t unpack(input logic [31:0] w);
    fp_t f;
    f.zero   = (w[30:23] == '0);
    f.inf    = (w[30:23] == '1) && (w[22:0] == '0);
    f.nan    = (w[30:23] == '1) && (w[22:0] != '0);
    f.m.sign = w[31];
    f.m.exp  = w[30:23];
    f.m.man  = f.zero ? '0 : {1'b1, w[22:0]};
    return f;
  endfunction
endpackage

// File: rtl/fpu_normalize.sv
// Leading-one normalisation, round-to-nearest-even and range clamping of a raw significand.
module fpu_normalize
  import pa_fpu::*;
(
  input  logic        sign_i,
  input  logic [9:0]  exp_i,
  input  logic [47:0] raw_i,
  output logic [31:0] res_o,
  output logic        ovf_o,
  output logic        unf_o
);
  // raw_i[46] carries weight 2^(exp_i - bias); exp_i is two's complement.
  logic [5:0]        lz;
  logic [46:0]       norm;
  logic              up;
  logic [MAN_W:0]    frac_r;
  logic signed [9:0] e;

  always_comb begin
    lz = 6'd48;
    for (int unsigned i = 0; i < 48; i++)
      if (raw_i[i]) lz = 6'(47 - i);
    norm   = 47'(raw_i << lz);
    up     = norm[23] & (norm[22] | (|norm[21:0]) | norm[24]);
    frac_r = {1'b0, norm[46:24]} + {{MAN_W{1'b0}}, up};
    e      = $signed(exp_i) + 10'sd1 - $signed({4'b0000, lz})
           + (frac_r[MAN_W] ? 10'sd1 : 10'sd0);
    res_o  = {sign_i, 31'b0};
    ovf_o  = 1'b0;
    unf_o  = 1'b0;
    if (raw_i != '0) begin
      if (e >= 10'sd255) begin
        res_o = {sign_i, 8'hFF, 23'b0};
        ovf_o = 1'b1;
      end else if (e <= 10'sd0) begin
        unf_o = 1'b1;
      end else begin
        res_o = {sign_i, e[7:0], frac_r[MAN_W-1:0]};
      end
    end
  end
endmodule

// File: rtl/fpu.sv
// Memory-mapped binary32 add/sub/mul coprocessor: bus register file, sequencer and datapath.
module fpu
  import pa_fpu::*;
(
  input  logic       clk,
  input  logic       arst,
  input  logic [7:0] databus_in,
  output logic [7:0] databus_out,
  input  logic [5:0] addr,
  input  logic       cs,
  input  logic       rd,
  input  logic       wr,
  input  logic       end_ack,
  output logic       cmd_end,
  output logic       busy
);
  state_t      state_q, state_d;
  logic [31:0] a_q, a_d, b_q, b_d, res_q, res_d;
  logic [7:0]  op_q, op_d;
  logic [2:0]  flags_q, flags_d;  // {underflow, overflow, invalid}
  logic        cmd_end_q, cmd_end_d;
  logic        wr_seen_q, wr_seen_d;
  unp_t        unp_q, unp_d;
  logic [26:0] aln_q, aln_d;
  raw_t        raw_q, raw_d;
  res_t        nrm_q, nrm_d;

  logic        wr_stb, is_mul, op_ok;
  logic [4:0]  lane;
  fp_t         fa, fb;
  logic [7:0]  dexp;
  logic [26:0] lo_ext, lo_sh;
  logic [27:0] sum;
  logic [31:0] n_res;
  logic        n_ovf, n_unf;

  assign busy      = (state_q != ST_IDLE);
  assign cmd_end   = cmd_end_q;
  assign lane      = {addr[1:0], 3'b000};
  assign wr_seen_d = !cs && !wr;
  assign wr_stb    = wr_seen_d && !wr_seen_q;

  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    op_d      = op_q;
    res_d     = res_q;
    flags_d   = flags_q;
    cmd_end_d = cmd_end_q && !end_ack;
    unique case (state_q)
      ST_IDLE: if (wr_stb) begin
        if (addr[5:2] == ADDR_A[5:2]) a_d[lane +: 8] = databus_in;
        else if (addr[5:2] == ADDR_B[5:2]) b_d[lane +: 8] = databus_in;
        else if (addr == ADDR_OP) begin
          op_d      = databus_in;
          flags_d   = '0;
          cmd_end_d = 1'b0;
          state_d   = ST_UNPACK;
        end
      end
      ST_UNPACK: state_d = ST_ALIGN;
      ST_ALIGN:  state_d = ST_EXEC;
      ST_EXEC:   state_d = ST_NORM;
      ST_NORM:   state_d = ST_ROUND;
      ST_ROUND: begin
        state_d   = ST_IDLE;
        res_d     = nrm_q.res;
        flags_d   = {nrm_q.unf, nrm_q.ovf, nrm_q.inv};
        cmd_end_d = 1'b1;
      end
      default:   state_d = ST_IDLE;
    endcase
  end

  // Classify operands and settle every special-value case up front.
  always_comb begin
    fa = unpack(a_q);
    fb = unpack(b_q);
    if (op_q == op_sub) fb.m.sign = ~fb.m.sign;
    is_mul = (op_q == op_mul);
    op_ok  = is_mul || (op_q == op_add) || (op_q == op_sub);
    unp_d  = unp_q;
    if (state_q == ST_UNPACK) begin
      unp_d.special = 1'b1;
      unp_d.sp_inv  = 1'b0;
      unp_d.sp_res  = '0;
      if ({fb.m.exp, fb.m.man} > {fa.m.exp, fa.m.man}) begin
        unp_d.hi = fb.m;
        unp_d.lo = fa.m;
      end else begin
        unp_d.hi = fa.m;
        unp_d.lo = fb.m;
      end
      if (!op_ok || fa.nan || fb.nan) begin
        unp_d.sp_res = QNAN;
        unp_d.sp_inv = 1'b1;
      end else if (is_mul) begin
        if ((fa.inf || fb.inf) && (fa.zero || fb.zero)) begin
          unp_d.sp_res = QNAN;
          unp_d.sp_inv = 1'b1;
        end else if (fa.inf || fb.inf) unp_d.sp_res = {fa.m.sign ^ fb.m.sign, 8'hFF, 23'b0};
        else if (fa.zero || fb.zero) unp_d.sp_res = {fa.m.sign ^ fb.m.sign, 31'b0};
        else unp_d.special = 1'b0;
      end else if (fa.inf && fb.inf && (fa.m.sign != fb.m.sign)) begin
        unp_d.sp_res = QNAN;
        unp_d.sp_inv = 1'b1;
      end else if (fa.inf) unp_d.sp_res = {fa.m.sign, 8'hFF, 23'b0};
      else if (fb.inf) unp_d.sp_res = {fb.m.sign, 8'hFF, 23'b0};
      else if (fa.zero && fb.zero) unp_d.sp_res = {fa.m.sign & fb.m.sign, 31'b0};
      else if (fa.zero) unp_d.sp_res = {fb.m.sign, b_q[30:0]};
      else if (fb.zero) unp_d.sp_res = a_q;
      else unp_d.special = 1'b0;
    end
  end

  // Smaller operand shifted right with the shifted-out bits folded into a sticky LSB.
  always_comb begin
    dexp   = unp_q.hi.exp - unp_q.lo.exp;
    lo_ext = {unp_q.lo.man, 3'b000};
    lo_sh  = lo_ext >> dexp;
    aln_d  = aln_q;
    if (state_q == ST_ALIGN)
      aln_d = {lo_sh[26:1], lo_sh[0] | ((lo_sh << dexp) != lo_ext)};
  end

  always_comb begin
    sum = (unp_q.hi.sign == unp_q.lo.sign) ? {1'b0, unp_q.hi.man, 3'b000} + {1'b0, aln_q}
                                           : {1'b0, unp_q.hi.man, 3'b000} - {1'b0, aln_q};
    raw_d = raw_q;
    if (state_q == ST_EXEC) begin
      if (op_q == op_mul) begin
        raw_d.sign = unp_q.hi.sign ^ unp_q.lo.sign;
        raw_d.exp  = {2'b00, unp_q.hi.exp} + {2'b00, unp_q.lo.exp} - 10'(BIAS);
        raw_d.raw  = {24'b0, unp_q.hi.man} * {24'b0, unp_q.lo.man};
      end else begin
        raw_d.sign = (sum == '0) ? 1'b0 : unp_q.hi.sign;
        raw_d.exp  = {2'b00, unp_q.hi.exp};
        raw_d.raw  = {sum, 20'b0};
      end
    end
  end

  fpu_normalize u_normalize (
    .sign_i (raw_q.sign),
    .exp_i  (raw_q.exp),
    .raw_i  (raw_q.raw),
    .res_o  (n_res),
    .ovf_o  (n_ovf),
    .unf_o  (n_unf)
  );

  always_comb begin
    nrm_d = nrm_q;
    if (state_q == ST_NORM) begin
      if (unp_q.special) begin
        nrm_d.res = unp_q.sp_res;
        nrm_d.inv = unp_q.sp_inv;
        nrm_d.ovf = 1'b0;
        nrm_d.unf = 1'b0;
      end else begin
        nrm_d.res = n_res;
        nrm_d.inv = 1'b0;
        nrm_d.ovf = n_ovf;
        nrm_d.unf = n_unf;
      end
    end
  end

  always_comb begin
    databus_out = '0;
    if (!cs && !rd) begin
      if (addr[5:2] == ADDR_A[5:2]) databus_out = a_q[lane +: 8];
      else if (addr[5:2] == ADDR_B[5:2]) databus_out = b_q[lane +: 8];
      else if (addr[5:2] == ADDR_RES[5:2]) databus_out = res_q[lane +: 8];
      else if (addr == ADDR_OP) databus_out = op_q;
      else if (addr == ADDR_STATUS) databus_out = {3'b000, flags_q, cmd_end_q, busy};
    end
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      state_q   <= ST_IDLE;
      a_q       <= '0;
      b_q       <= '0;
      op_q      <= '0;
      res_q     <= '0;
      flags_q   <= '0;
      cmd_end_q <= 1'b0;
      wr_seen_q <= 1'b0;
      unp_q     <= '0;
      aln_q     <= '0;
      raw_q     <= '0;
      nrm_q     <= '0;
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      b_q       <= b_d;
      op_q      <= op_d;
      res_q     <= res_d;
      flags_q   <= flags_d;
      cmd_end_q <= cmd_end_d;
      wr_seen_q <= wr_seen_d;
      unp_q     <= unp_d;
      aln_q     <= aln_d;
      raw_q     <= raw_d;
      nrm_q     <= nrm_d;
    end
  end
endmodule

// File: tb/tb_fpu.sv
// Directed-vector bench for fpu: bus access, op latency, arithmetic corner cases, reset abort.
module tb_fpu;
  import pa_fpu::*;

  logic       clk = 1'b0;
  logic       arst;
  logic [7:0] databus_in, databus_out;
  logic [5:0] addr;
  logic       cs, rd, wr, end_ack, cmd_end, busy;

  int unsigned n_total = 0;
  int unsigned n_pass  = 0;
  int          busy_cycles;
  logic        ce_early;
  logic [7:0]  exp_b [4] = '{8'h00, 8'h00, 8'h40, 8'h40};

  fpu dut (
    .clk         (clk),
    .arst        (arst),
    .databus_in  (databus_in),
    .databus_out (databus_out),
    .addr        (addr),
    .cs          (cs),
    .rd          (rd),
    .wr          (wr),
    .end_ack     (end_ack),
    .cmd_end     (cmd_end),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
  endtask

  task automatic bus_write(input logic [5:0] a, input logic [7:0] d);
    addr = a; databus_in = d; cs = 1'b0; wr = 1'b0;
    @(negedge clk);
    cs = 1'b1; wr = 1'b1;
    @(negedge clk);
  endtask

  task automatic bus_read(input logic [5:0] a, output logic [7:0] d);
    addr = a; cs = 1'b0; rd = 1'b0;
    #1 d = databus_out;
    cs = 1'b1; rd = 1'b1;
  endtask

  task automatic write_word(input logic [5:0] base, input logic [31:0] w);
    for (int unsigned i = 0; i < 4; i++) bus_write(base + 6'(i), w[8*i +: 8]);
  endtask

  task automatic read_word(input logic [5:0] base, output logic [31:0] w);
    logic [7:0] b;
    for (int unsigned i = 0; i < 4; i++) begin
      bus_read(base + 6'(i), b);
      w[8*i +: 8] = b;
    end
  endtask

  task automatic start_op(input logic [7:0] op);
    addr = ADDR_OP; databus_in = op; cs = 1'b0; wr = 1'b0;
    @(negedge clk);
    cs = 1'b1; wr = 1'b1;
    ce_early    = cmd_end;
    busy_cycles = 0;
    while (busy && busy_cycles < 20) begin
      busy_cycles++;
      @(negedge clk);
    end
  endtask

  task automatic run(input string tag, input logic [31:0] a, input logic [31:0] b,
                     input logic [7:0] op, input logic [31:0] exp_res, input logic [7:0] exp_st);
    logic [31:0] r;
    logic [7:0]  s;
    write_word(ADDR_A, a);
    write_word(ADDR_B, b);
    start_op(op);
    check({tag, " busy cycles"}, busy_cycles, 32'd5);
    read_word(ADDR_RES, r);
    check({tag, " res"}, r, exp_res);
    bus_read(ADDR_STATUS, s);
    check({tag, " status"}, {24'b0, s}, {24'b0, exp_st});
  endtask

  initial begin
    logic [31:0] w;
    logic [7:0]  s;
    arst = 1'b1; cs = 1'b1; rd = 1'b1; wr = 1'b1; end_ack = 1'b0;
    addr = '0; databus_in = '0;
    repeat (3) @(negedge clk);
    arst = 1'b0;
    @(negedge clk);

    check("rst busy", 32'(busy), 32'd0);
    check("rst cmd_end", 32'(cmd_end), 32'd0);
    bus_read(ADDR_STATUS, s);
    check("rst status", {24'b0, s}, 32'd0);
    read_word(ADDR_RES, w);
    check("rst res", w, 32'd0);

    run("nan add", 32'hFFFF_FFFF, 32'hFFFF_FFFF, op_add, 32'h7FC0_0000, 8'h06);
    check("nan cmd_end", 32'(cmd_end), 32'd1);
    end_ack = 1'b1;
    @(negedge clk);
    end_ack = 1'b0;
    check("ack cmd_end", 32'(cmd_end), 32'd0);

    run("1+2", 32'h3F80_0000, 32'h4000_0000, op_add, 32'h4040_0000, 8'h02);
    for (int unsigned i = 0; i < 4; i++) begin
      bus_read(ADDR_RES + 6'(i), s);
      check("res byte", {24'b0, s}, {24'b0, exp_b[i]});
    end

    run("3-1", 32'h4040_0000, 32'h3F80_0000, op_sub, 32'h4000_0000, 8'h02);
    check("op write clears cmd_end", 32'(ce_early), 32'd0);
    run("3-3", 32'h4040_0000, 32'h4040_0000, op_sub, 32'h0000_0000, 8'h02);
    run("2*3", 32'h4000_0000, 32'h4040_0000, op_mul, 32'h40C0_0000, 8'h02);
    run("max+max", 32'h7F7F_FFFF, 32'h7F7F_FFFF, op_add, 32'h7F80_0000, 8'h0A);
    run("bad opcode", 32'h3F80_0000, 32'h3F80_0000, 8'h05, 32'h7FC0_0000, 8'h06);
    run("inf-inf", 32'h7F80_0000, 32'h7F80_0000, op_sub, 32'h7FC0_0000, 8'h06);
    run("-0+-0", 32'h8000_0000, 32'h8000_0000, op_add, 32'h8000_0000, 8'h02);
    run("0*inf", 32'h0000_0000, 32'hFF80_0000, op_mul, 32'h7FC0_0000, 8'h06);
    run("-inf*2", 32'hFF80_0000, 32'h4000_0000, op_mul, 32'hFF80_0000, 8'h02);
    run("tie to even", 32'h3F80_0000, 32'h3380_0000, op_add, 32'h3F80_0000, 8'h02);
    run("round up", 32'h3F80_0000, 32'h33C0_0000, op_add, 32'h3F80_0001, 8'h02);
    run("mul underflow", 32'h0D80_0000, 32'h0D80_0000, op_mul, 32'h0000_0000, 8'h12);

    // A strobe held low across several edges must only write once.
    addr = ADDR_A; databus_in = 8'h11; cs = 1'b0; wr = 1'b0;
    @(negedge clk);
    databus_in = 8'h22;
    @(negedge clk);
    databus_in = 8'h33;
    @(negedge clk);
    cs = 1'b1; wr = 1'b1;
    @(negedge clk);
    bus_read(ADDR_A, s);
    check("held strobe", {24'b0, s}, 32'h11);

    // Writes to A and OP while busy must be dropped.
    write_word(ADDR_A, 32'h4000_0000);
    write_word(ADDR_B, 32'h4040_0000);
    addr = ADDR_OP; databus_in = op_mul; cs = 1'b0; wr = 1'b0;
    @(negedge clk);
    cs = 1'b1; wr = 1'b1;
    @(negedge clk);
    addr = ADDR_A + 6'd3; databus_in = 8'h3F; cs = 1'b0; wr = 1'b0;
    @(negedge clk);
    cs = 1'b1; wr = 1'b1;
    @(negedge clk);
    addr = ADDR_OP; databus_in = op_add; cs = 1'b0; wr = 1'b0;
    @(negedge clk);
    cs = 1'b1; wr = 1'b1;
    check("busy at second op write", 32'(busy), 32'd1);
    busy_cycles = 0;
    while (busy && busy_cycles < 20) begin
      busy_cycles++;
      @(negedge clk);
    end
    check("busy-write done", 32'(busy), 32'd0);
    read_word(ADDR_RES, w);
    check("busy-write res", w, 32'h40C0_0000);
    bus_read(ADDR_A + 6'd3, s);
    check("busy-write A byte3", {24'b0, s}, 32'h40);
    repeat (3) @(negedge clk);
    check("no deferred op", 32'(busy), 32'd0);

    // Reset while the sequencer sits in ALIGN.
    addr = ADDR_OP; databus_in = op_add; cs = 1'b0; wr = 1'b0;
    @(negedge clk);
    cs = 1'b1; wr = 1'b1;
    @(posedge clk);
    #1;
    check("busy before abort", 32'(busy), 32'd1);
    arst = 1'b1;
    #1;
    check("abort busy", 32'(busy), 32'd0);
    check("abort cmd_end", 32'(cmd_end), 32'd0);
    @(negedge clk);
    arst = 1'b0;
    @(negedge clk);
    read_word(ADDR_RES, w);
    check("abort res", w, 32'd0);
    read_word(ADDR_A, w);
    check("abort A", w, 32'd0);
    read_word(ADDR_B, w);
    check("abort B", w, 32'd0);
    bus_read(ADDR_STATUS, s);
    check("abort status", {24'b0, s}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
